// File: rtl/gpp_isa_pkg.sv
// Shared ISA constants for the program-loader encoder: instruction type codes,
// opcode ranges, register selects, error causes and the loader FSM states.
package gpp_isa_pkg;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_LDST = 2'b01;
    localparam logic [1:0] TYPE_BR   = 2'b10;
    localparam logic [1:0] TYPE_ALU  = 2'b11;

    localparam logic [5:0] LDST_OP_MIN = 6'd1;
    localparam logic [5:0] LDST_OP_MAX = 6'd2;
    localparam logic [5:0] BR_OP_MIN   = 6'd3;
    localparam logic [5:0] BR_OP_MAX   = 6'd9;
    localparam logic [5:0] ALU_OP_MIN  = 6'd1;
    localparam int         ALU_OFFSET_DFLT = 9;

    localparam logic [1:0] REG_X = 2'b01;
    localparam logic [1:0] REG_Y = 2'b10;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_REG    = 2'b10;
    localparam logic [1:0] ERR_TYPE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCEPT = 2'b01,
        WRITE  = 2'b10,
        DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of one instruction field set into a 16-bit word,
// with validity check and the error cause for rejected field sets.
module instr_pack
    import gpp_isa_pkg::*;
#(
    parameter int ALU_OFFSET = ALU_OFFSET_DFLT
) (
    input  logic [1:0]  in_type,
    input  logic [5:0]  opcode,
    input  logic [1:0]  reg_sel,
    input  logic [8:0]  operand,
    output logic [15:0] word,
    output logic        valid,
    output logic [1:0]  err_code
);

    localparam logic [5:0] ALU_OP_MAX = 6'(63 - ALU_OFFSET);
    localparam logic [5:0] ALU_ADD    = 6'(ALU_OFFSET);

    logic [5:0] op_field;
    logic       reg_bit;
    logic       op_bad;
    logic       reg_bad;
    logic       reg_ok;

    assign reg_ok = (reg_sel == REG_X) || (reg_sel == REG_Y);

    always_comb begin
        op_field = opcode;
        reg_bit  = (reg_sel == REG_Y);
        op_bad   = 1'b0;
        reg_bad  = 1'b0;
        case (in_type)
            TYPE_LDST: begin
                op_bad  = (opcode < LDST_OP_MIN) || (opcode > LDST_OP_MAX);
                reg_bad = !reg_ok;
            end
            TYPE_BR: begin
                op_bad  = (opcode < BR_OP_MIN) || (opcode > BR_OP_MAX);
                reg_bit = 1'b0;
            end
            TYPE_ALU: begin
                op_bad   = (opcode < ALU_OP_MIN) || (opcode > ALU_OP_MAX);
                reg_bad  = !reg_ok;
                op_field = opcode + ALU_ADD;
            end
            default: begin
            end
        endcase

        // Opcode errors take priority over register errors.
        if (in_type == TYPE_NONE) begin
            err_code = ERR_TYPE;
        end else if (op_bad) begin
            err_code = ERR_OPCODE;
        end else if (reg_bad) begin
            err_code = ERR_REG;
        end else begin
            err_code = ERR_NONE;
        end

        valid = (err_code == ERR_NONE);
        word  = {op_field, reg_bit, operand};
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction field sets, encodes them and writes them
// sequentially into program memory, one word every two cycles.
module instr_encoder
    import gpp_isa_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int ALU_OFFSET = ALU_OFFSET_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [5:0]        in_opcode,
    input  logic [1:0]        in_reg,
    input  logic [8:0]        in_operand,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        word_q;
    logic               last_q;
    logic [15:0]        pack_word;
    logic               pack_valid;
    logic [1:0]         pack_err;
    logic               xfer;
    logic               at_max;

    instr_pack #(
        .ALU_OFFSET(ALU_OFFSET)
    ) u_pack (
        .in_type  (in_type),
        .opcode   (in_opcode),
        .reg_sel  (in_reg),
        .operand  (in_operand),
        .word     (pack_word),
        .valid    (pack_valid),
        .err_code (pack_err)
    );

    assign xfer   = in_valid && in_ready;
    assign at_max = (addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (pack_valid)   state_next = WRITE;
                    else if (in_last) state_next = DONE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                busy       = 1'b1;
                state_next = (last_q || at_max) ? DONE : ACCEPT;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = ACCEPT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address saturates at the top of memory; full marks that it was written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            full     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr     <= '0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        full     <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (xfer) begin
                        if (pack_valid) begin
                            word_q <= pack_word;
                            last_q <= in_last;
                        end else begin
                            err <= 1'b1;
                            if (!err) err_code <= pack_err;
                        end
                    end
                end
                WRITE: begin
                    if (at_max) full <= 1'b1;
                    else        addr <= addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = addr;
    assign mem_wdata = word_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, error handling, memory-full and
// reset-during-write behaviour against hand-computed expectations.
module tb_instr_encoder;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [1:0]        in_type = 2'b00;
    logic [5:0]        in_opcode = 6'd0;
    logic [1:0]        in_reg = 2'b00;
    logic [8:0]        in_operand = 9'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W     (ADDR_W),
        .ALU_OFFSET (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_opcode  (in_opcode),
        .in_reg     (in_reg),
        .in_operand (in_operand),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {in_ready, mem_we, busy, done, full, err, err_code, mem_addr, mem_wdata}, 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic [5:0] op, input logic [1:0] r,
                        input logic [8:0] opd, input logic last);
        in_valid   = 1'b1;
        in_type    = t;
        in_opcode  = op;
        in_reg     = r;
        in_operand = opd;
        in_last    = last;
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_quiet("reset_outputs");
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("idle_outputs");

        // Single load/store word, last of program
        do_start();
        chk("accept_ready", in_ready, 1);
        chk("accept_busy", busy, 1);
        send(2'b01, 6'd2, 2'b01, 9'd1, 1'b1);
        chk("ldst_we", mem_we, 1);
        chk("ldst_addr", mem_addr, 0);
        chk("ldst_wdata", mem_wdata, 16'h0801);
        chk("ldst_ready_in_write", in_ready, 0);
        @(negedge clk);
        chk("ldst_done", done, 1);
        chk("ldst_busy_off", busy, 0);
        chk("ldst_we_off", mem_we, 0);
        chk("ldst_addr_inc", mem_addr, 1);

        // Branch then ALU with last
        do_start();
        chk("restart_addr", mem_addr, 0);
        send(2'b10, 6'd3, 2'b00, 9'd2, 1'b0);
        chk("br_we", mem_we, 1);
        chk("br_addr", mem_addr, 0);
        chk("br_wdata", mem_wdata, 16'h0C02);
        @(negedge clk);
        chk("br_back_accept", in_ready, 1);
        send(2'b11, 6'd1, 2'b10, 9'd3, 1'b1);
        chk("alu_we", mem_we, 1);
        chk("alu_addr", mem_addr, 1);
        chk("alu_wdata", mem_wdata, 16'h2A03);
        @(negedge clk);
        chk("alu_done", done, 1);
        chk("alu_addr_after", mem_addr, 2);

        // Invalid words: opcode range, then type 00 keeps first cause
        do_start();
        send(2'b01, 6'd5, 2'b01, 9'h0AA, 1'b0);
        chk("badop_we", mem_we, 0);
        chk("badop_err", err, 1);
        chk("badop_code", err_code, 2'b01);
        chk("badop_addr", mem_addr, 0);
        chk("badop_ready", in_ready, 1);
        send(2'b00, 6'd1, 2'b01, 9'd0, 1'b0);
        chk("type0_code_sticky", err_code, 2'b01);
        chk("type0_we", mem_we, 0);
        send(2'b11, 6'd54, 2'b01, 9'h1FF, 1'b1);
        chk("alu_max_we", mem_we, 1);
        chk("alu_max_addr", mem_addr, 0);
        chk("alu_max_wdata", mem_wdata, 16'hFDFF);
        chk("alu_max_err_kept", err, 1);
        @(negedge clk);
        chk("alu_max_done", done, 1);

        // Restart clears error; illegal register, start ignored while active
        do_start();
        chk("restart_err", {err, err_code}, 0);
        send(2'b11, 6'd1, 2'b00, 9'd0, 1'b0);
        chk("badreg_code", err_code, 2'b10);
        do_start();
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_code", err_code, 2'b10);
        send(2'b11, 6'd55, 2'b01, 9'd0, 1'b1);
        chk("alu_over_done", done, 1);
        chk("alu_over_code_sticky", err_code, 2'b10);
        chk("alu_over_addr", mem_addr, 0);

        do_start();
        send(2'b01, 6'd5, 2'b00, 9'd0, 1'b1);
        chk("prio_code", err_code, 2'b01);
        chk("prio_done", done, 1);
        do_start();
        send(2'b10, 6'd10, 2'b01, 9'd0, 1'b1);
        chk("br_over_code", err_code, 2'b01);
        do_start();
        send(2'b00, 6'd1, 2'b01, 9'd0, 1'b1);
        chk("type0_code", err_code, 2'b11);

        // Fill the whole memory with in_valid held high
        do_start();
        in_valid  = 1'b1;
        in_type   = 2'b01;
        in_opcode = 6'd1;
        in_reg    = 2'b01;
        in_last   = 1'b0;
        for (int i = 0; i < 512; i++) begin
            in_operand = 9'(i);
            @(negedge clk);
            chk("fill_we", mem_we, 1);
            chk("fill_addr", mem_addr, i);
            chk("fill_wdata", mem_wdata, 16'h0400 | i);
            if (i == 510) chk("fill_not_full", full, 0);
            @(negedge clk);
        end
        chk("full_flag", full, 1);
        chk("full_done", done, 1);
        chk("full_ready", in_ready, 0);
        chk("full_addr", mem_addr, 511);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_no_extra_we", mem_we, 0);
            chk("full_addr_hold", mem_addr, 511);
        end
        in_valid = 1'b0;

        // Reset asserted during the write cycle
        do_start();
        chk("after_full_restart_addr", mem_addr, 0);
        chk("after_full_restart_full", full, 0);
        send(2'b10, 6'd9, 2'b00, 9'h155, 1'b0);
        chk("prerst_we", mem_we, 1);
        chk("prerst_wdata", mem_wdata, 16'h2555);
        #2 rst = 1'b0;
        #1 chk_quiet("rst_in_write");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst_idle");
        do_start();
        send(2'b01, 6'd1, 2'b10, 9'd7, 1'b1);
        chk("post_rst_we", mem_we, 1);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wdata", mem_wdata, 16'h0607);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
